// File: rtl/demosaic_pkg.sv
// Shared types and helpers for the green-plane demosaic stage: CFA phases,
// site classification and {R,G,B} output packing.
package demosaic_pkg;

    localparam int PIX_W = 8;

    localparam logic [1:0] BAYER_RGGB = 2'd0;
    localparam logic [1:0] BAYER_GRBG = 2'd1;
    localparam logic [1:0] BAYER_GBRG = 2'd2;
    localparam logic [1:0] BAYER_BGGR = 2'd3;

    typedef enum logic [1:0] {SITE_R, SITE_G, SITE_B} site_e;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

    // Each phase is RGGB with the row and/or column parity flipped.
    function automatic site_e site_of(input logic [1:0] bayer, input logic r0, input logic c0);
        logic er;
        logic ec;
        case (bayer)
            BAYER_RGGB: begin er = r0;  ec = c0;  end
            BAYER_GRBG: begin er = r0;  ec = ~c0; end
            BAYER_GBRG: begin er = ~r0; ec = c0;  end
            default:    begin er = ~r0; ec = ~c0; end
        endcase
        if (!er && !ec)
            return SITE_R;
        else if (er && ec)
            return SITE_B;
        return SITE_G;
    endfunction

    function automatic logic [3*PIX_W-1:0] pack(input site_e site, input logic [PIX_W-1:0] raw,
                                                 input logic [PIX_W-1:0] g);
        case (site)
            SITE_R:  return {raw, g, {PIX_W{1'b0}}};
            SITE_B:  return {{PIX_W{1'b0}}, g, raw};
            default: return {{PIX_W{1'b0}}, raw, {PIX_W{1'b0}}};
        endcase
    endfunction

endpackage

// File: rtl/demosaic_line_buffer.sv
// One-row delay line: DEPTH x PIX_W memory with a registered read port.
// The caller runs the read address one column ahead of the write address.
module demosaic_line_buffer
    import demosaic_pkg::*;
#(
    parameter int DEPTH = 512
) (
    input  logic                       clk_i,
    input  logic                       wr_en_i,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr_i,
    input  logic [PIX_W-1:0]           wr_data_i,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr_i,
    output logic [PIX_W-1:0]           rd_data_o
);

    logic [PIX_W-1:0] mem_q [DEPTH];
    logic [PIX_W-1:0] rd_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i)
            mem_q[wr_addr_i] <= wr_data_i;
        rd_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_q;

endmodule

// File: rtl/demosaic_interp_g.sv
// Green-plane interpolation: Bayer stream in, {R,G,B} per pixel out, with a
// full green value everywhere and the raw R/B sample kept in its own channel.
module demosaic_interp_g
    import demosaic_pkg::*;
#(
    parameter int         IMG_W = 512,
    parameter int         IMG_H = 768,
    parameter logic [1:0] BAYER = BAYER_RGGB
) (
    input  logic                 INCLK,
    input  logic                 RST,
    input  logic [PIX_W-1:0]     RAW,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    output logic [3*PIX_W-1:0]   DATA,
    output logic                 OUT_EN
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    state_e            state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     ocol_q, ocol_d;
    logic [RW-1:0]     orow_q, orow_d;
    logic [3*PIX_W-1:0] data_q, data_d;
    logic              out_en_q;

    logic accept, advance, emit, last_in, last_out;

    // Window: column k-1 (top/mid/bot) plus the centre row of column k-2.
    logic [PIX_W-1:0] top_q, mid_q, bot_q, left_q;
    logic [PIX_W-1:0] lb1_rd, lb2_rd;

    assign IN_READY = (state_q != FLUSH);
    assign accept   = IN_VALID && IN_READY;
    // During FLUSH the pipeline keeps stepping on phantom samples; mirroring
    // guarantees none of them reach an output.
    assign advance  = accept || (state_q == FLUSH);
    assign last_in  = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
    assign last_out = (orow_q == RW'(IMG_H - 1)) && (ocol_q == CW'(IMG_W - 1));
    assign emit     = (state_q == FLUSH) ||
                      (accept && ((row_q >= RW'(2)) || ((row_q == RW'(1)) && (col_q != '0))));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (accept && last_in) state_d = FLUSH;
            FLUSH:   if (last_out) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        ocol_d = ocol_q;
        orow_d = orow_q;
        if (state_q == FLUSH && last_out) begin
            col_d = '0;
            row_d = '0;
        end else if (advance) begin
            if (col_q == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
        if (emit) begin
            if (ocol_q == CW'(IMG_W - 1)) begin
                ocol_d = '0;
                orow_d = (orow_q == RW'(IMG_H - 1)) ? '0 : orow_q + RW'(1);
            end else begin
                ocol_d = ocol_q + CW'(1);
            end
        end
    end

    // Read address is the next column so the registered read is ready in
    // the cycle that column's sample is accepted; it is read before rewrite.
    demosaic_line_buffer #(.DEPTH(IMG_W)) u_lb1 (
        .clk_i     (INCLK),
        .wr_en_i   (advance),
        .wr_addr_i (col_q),
        .wr_data_i (RAW),
        .rd_addr_i (col_d),
        .rd_data_o (lb1_rd)
    );

    demosaic_line_buffer #(.DEPTH(IMG_W)) u_lb2 (
        .clk_i     (INCLK),
        .wr_en_i   (advance),
        .wr_addr_i (col_q),
        .wr_data_i (lb1_rd),
        .rd_addr_i (col_d),
        .rd_data_o (lb2_rd)
    );

    always_ff @(posedge INCLK) begin
        if (advance) begin
            left_q <= mid_q;
            top_q  <= lb2_rd;
            mid_q  <= lb1_rd;
            bot_q  <= RAW;
        end
    end

    logic [PIX_W-1:0] up, dn, lf, rt;
    logic [9:0]       sum;

    // Mirror across frame edges; wrapped window data is never selected.
    always_comb begin
        up     = (orow_q == '0) ? bot_q : top_q;
        dn     = (orow_q == RW'(IMG_H - 1)) ? top_q : bot_q;
        lf     = (ocol_q == '0) ? lb1_rd : left_q;
        rt     = (ocol_q == CW'(IMG_W - 1)) ? left_q : lb1_rd;
        sum    = 10'(up) + 10'(dn) + 10'(lf) + 10'(rt) + 10'd2;
        data_d = pack(site_of(BAYER, orow_q[0], ocol_q[0]), mid_q, sum[9:2]);
    end

    always_ff @(posedge INCLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            col_q    <= '0;
            row_q    <= '0;
            ocol_q   <= '0;
            orow_q   <= '0;
            data_q   <= '0;
            out_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            ocol_q   <= ocol_d;
            orow_q   <= orow_d;
            out_en_q <= emit;
            if (emit)
                data_q <= data_d;
        end
    end

    assign DATA   = data_q;
    assign OUT_EN = out_en_q;

endmodule
